// File: rtl/serial_test_seq_pkg.sv
// Shared constants, state/phase enums and small helpers for the serial test sequencer.
package serial_test_seq_pkg;

   // Major/minor state codes driven by the timing-state generator.
   localparam logic [4:0] ST_F0 = 5'd0;
   localparam logic [4:0] ST_F1 = 5'd1;
   localparam logic [4:0] ST_F2 = 5'd2;
   localparam logic [4:0] ST_F3 = 5'd3;

   localparam logic [2:0]  IOT_OP = 3'o6;
   localparam logic [2:0]  FN_SKF = 3'o1;
   localparam logic [2:0]  FN_XFR = 3'o6;
   localparam logic [11:0] NOP    = 12'o7000;

   localparam int MODE_TX   = 0;
   localparam int MODE_ECHO = 1;
   localparam int MODE_LOOP = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TSF_POLL,
      S_TLS,
      S_KSF_POLL,
      S_KRB,
      S_CHECK
   } seq_state_t;

   typedef enum logic [1:0] {
      PH_DATA,
      PH_CR,
      PH_LF
   } char_phase_t;

   function automatic logic [11:0] iot_word(input logic [5:0] dev, input logic [2:0] fn);
      return {IOT_OP, dev, fn};
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/serial_test_seq_char_gen.sv
// Message character generator: START_CHAR+idx for MSG_LEN characters, optional CR/LF tail.
// msg_end pulses combinationally on the advance that consumes the last character of a message.
module serial_test_seq_char_gen
   import serial_test_seq_pkg::*;
#(
   parameter int         MSG_LEN    = 16,
   parameter logic [7:0] START_CHAR = 8'h41,
   parameter bit         CRLF       = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       advance,
   output logic [7:0] char_out,
   output logic       msg_end
);

   localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

   logic [7:0]  idx;
   char_phase_t phase;

   always_comb begin
      char_out = START_CHAR + idx;
      if (phase == PH_CR) char_out = 8'h0D;
      if (phase == PH_LF) char_out = 8'h0A;
      msg_end = advance &&
                (((phase == PH_DATA) && (idx == LAST_IDX) && !CRLF) || (phase == PH_LF));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         idx   <= 8'd0;
         phase <= PH_DATA;
      end else if (advance) begin
         case (phase)
            PH_DATA: begin
               if (idx == LAST_IDX) begin
                  idx   <= 8'd0;
                  phase <= CRLF ? PH_CR : PH_DATA;
               end else begin
                  idx <= idx + 8'd1;
               end
            end
            PH_CR:   phase <= PH_LF;
            default: phase <= PH_DATA;
         endcase
      end
   end

endmodule

// File: rtl/serial_test_seq.sv
// CPU-less stimulus sequencer for the serial block: issues IOTs/AC on F0, samples skip on F3,
// runs transmit, echo or loopback-check modes and keeps pass/error statistics.
module serial_test_seq
   import serial_test_seq_pkg::*;
#(
   parameter logic [5:0] KBD_DEV    = 6'o03,
   parameter logic [5:0] TTY_DEV    = 6'o04,
   parameter int         MODE       = 0,
   parameter int         MSG_LEN    = 16,
   parameter logic [7:0] START_CHAR = 8'h41,
   parameter bit         ADD_CRLF   = 1'b1,
   parameter int         TIMEOUT    = 4095
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  state,
   input  logic        skip,
   input  logic [7:0]  rx_data,
   output logic [11:0] instruction,
   output logic [11:0] ac,
   output logic [7:0]  pass_count,
   output logic [7:0]  err_count,
   output logic        timeout_flag,
   output logic        busy
);

   localparam seq_state_t ENTRY   = (MODE == MODE_ECHO) ? S_KSF_POLL : S_TSF_POLL;
   localparam logic [11:0] TO_MAX = 12'(TIMEOUT);

   seq_state_t  fsm, fsm_nxt;
   logic [11:0] poll_cnt, poll_nxt;
   logic [7:0]  rx_latch;
   logic [7:0]  gen_char, tx_char;
   logic [11:0] issue;
   logic        advance, timeout, mismatch, msg_end, msg_bad;

   serial_test_seq_char_gen #(
      .MSG_LEN    (MSG_LEN),
      .START_CHAR (START_CHAR),
      .CRLF       (ADD_CRLF && (MODE != MODE_ECHO))
   ) u_char_gen (
      .clock    (clock),
      .reset    (reset),
      .advance  (advance),
      .char_out (gen_char),
      .msg_end  (msg_end)
   );

   assign tx_char = (MODE == MODE_ECHO) ? rx_latch : gen_char;
   assign busy    = (fsm != S_IDLE);

   always_ff @(posedge clock) begin
      if (reset) fsm <= S_IDLE;
      else       fsm <= fsm_nxt;
   end

   // Transitions happen on F3 once skip/rx_data are known; IDLE leaves on F0 so the
   // entry IOT goes out in that same slot.
   always_comb begin
      fsm_nxt  = fsm;
      poll_nxt = poll_cnt;
      advance  = 1'b0;
      timeout  = 1'b0;
      mismatch = 1'b0;
      if (state == ST_F0 && fsm == S_IDLE) begin
         fsm_nxt = ENTRY;
      end else if (state == ST_F3) begin
         case (fsm)
            S_TSF_POLL, S_KSF_POLL: begin
               if (skip) begin
                  poll_nxt = 12'd0;
                  fsm_nxt  = (fsm == S_TSF_POLL) ? S_TLS : S_KRB;
               end else if (poll_cnt == TO_MAX) begin
                  poll_nxt = 12'd0;
                  timeout  = 1'b1;
                  advance  = 1'b1;
                  fsm_nxt  = ENTRY;
               end else begin
                  poll_nxt = poll_cnt + 12'd1;
               end
            end
            S_TLS: begin
               fsm_nxt = (MODE == MODE_TX) ? S_TSF_POLL : S_KSF_POLL;
               advance = (MODE != MODE_LOOP);
            end
            S_KRB:   fsm_nxt = (MODE == MODE_ECHO) ? S_TSF_POLL : S_CHECK;
            S_CHECK: begin
               mismatch = (rx_latch != gen_char);
               advance  = 1'b1;
               fsm_nxt  = S_TSF_POLL;
            end
            default: fsm_nxt = fsm;
         endcase
      end
   end

   always_comb begin
      issue = NOP;
      case (fsm_nxt)
         S_TSF_POLL: issue = iot_word(TTY_DEV, FN_SKF);
         S_TLS:      issue = iot_word(TTY_DEV, FN_XFR);
         S_KSF_POLL: issue = iot_word(KBD_DEV, FN_SKF);
         S_KRB:      issue = iot_word(KBD_DEV, FN_XFR);
         default:    issue = NOP;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         instruction  <= NOP;
         ac           <= 12'd0;
         poll_cnt     <= 12'd0;
         rx_latch     <= 8'd0;
         pass_count   <= 8'd0;
         err_count    <= 8'd0;
         timeout_flag <= 1'b0;
         msg_bad      <= 1'b0;
      end else begin
         poll_cnt <= poll_nxt;
         if (state == ST_F0) begin
            instruction <= issue;
            if (fsm_nxt == S_TLS) ac <= {4'b0, tx_char};
         end
         if (state == ST_F3 && fsm == S_KRB) rx_latch <= rx_data;
         if (timeout) timeout_flag <= 1'b1;
         if (timeout || mismatch) err_count <= sat_inc(err_count);
         // A message passes only if nothing failed, including a failure on its final step.
         if (msg_end) begin
            if (!(msg_bad || timeout || mismatch)) pass_count <= sat_inc(pass_count);
            msg_bad <= 1'b0;
         end else if (timeout || mismatch) begin
            msg_bad <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_test_seq.sv
// Directed bench: three sequencer instances (transmit, loopback, echo) share one stimulus bus.
module tb_serial_test_seq;
   import serial_test_seq_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [4:0]  state = ST_F1;
   logic        skip = 1'b0;
   logic [7:0]  rx_data = 8'h00;

   logic [11:0] ins0, ac0, ins2, ac2, ins1, ac1;
   logic [7:0]  pass0, err0, pass2, err2, pass1, err1;
   logic        to0, to2, to1, busy0, busy2, busy1;

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   serial_test_seq #(.MODE(0), .MSG_LEN(3), .TIMEOUT(4)) u_tx (
      .clock(clock), .reset(reset), .state(state), .skip(skip), .rx_data(rx_data),
      .instruction(ins0), .ac(ac0), .pass_count(pass0), .err_count(err0),
      .timeout_flag(to0), .busy(busy0));

   serial_test_seq #(.MODE(2), .MSG_LEN(3), .TIMEOUT(4)) u_loop (
      .clock(clock), .reset(reset), .state(state), .skip(skip), .rx_data(rx_data),
      .instruction(ins2), .ac(ac2), .pass_count(pass2), .err_count(err2),
      .timeout_flag(to2), .busy(busy2));

   serial_test_seq #(.MODE(1), .MSG_LEN(2), .TIMEOUT(4)) u_echo (
      .clock(clock), .reset(reset), .state(state), .skip(skip), .rx_data(rx_data),
      .instruction(ins1), .ac(ac1), .pass_count(pass1), .err_count(err1),
      .timeout_flag(to1), .busy(busy1));

   // One instruction slot F0..F3; state is left at a neutral code between slots.
   task automatic slot();
      state = ST_F0; @(posedge clock); #1;
      state = ST_F1; @(posedge clock); #1;
      state = ST_F2; @(posedge clock); #1;
      state = ST_F3; @(posedge clock); #1;
      state = ST_F1;
   endtask

   task automatic do_reset();
      reset = 1'b1; state = ST_F1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (ins0 !== 12'o7000) begin bad++; $display("FAIL reset_ins got %o want 7000", ins0); end
      total++; if (ac0 !== 12'o0) begin bad++; $display("FAIL reset_ac got %o want 0", ac0); end
      total++; if ({pass0, err0, to0, busy0} !== 18'd0) begin bad++;
         $display("FAIL reset_stats got pass=%0d err=%0d to=%0d busy=%0d want 0", pass0, err0, to0, busy0); end
      total++; if (busy2 !== 1'b0 || busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy_other got %b%b want 00", busy2, busy1); end
   endtask

   task automatic test_transmit();
      logic [11:0] ac_tab [5] = '{12'o0101, 12'o0102, 12'o0103, 12'o0015, 12'o0012};
      do_reset();
      skip = 1'b1;
      for (int i = 0; i < 12; i++) begin
         slot();
         total++; if (ins0 !== ((i % 2 == 0) ? 12'o6041 : 12'o6046)) begin bad++;
            $display("FAIL tx_ins[%0d] got %o want %o", i, ins0, (i % 2 == 0) ? 12'o6041 : 12'o6046); end
         if (i % 2 == 1) begin
            total++; if (ac0 !== ac_tab[(i / 2) % 5]) begin bad++;
               $display("FAIL tx_ac[%0d] got %o want %o", i, ac0, ac_tab[(i / 2) % 5]); end
         end
         if (i == 7) begin
            total++; if (pass0 !== 8'd0) begin bad++; $display("FAIL tx_pass_before_lf got %0d want 0", pass0); end
         end
         if (i == 9) begin
            total++; if (pass0 !== 8'd1) begin bad++; $display("FAIL tx_pass_after_lf got %0d want 1", pass0); end
         end
      end
      total++; if (busy0 !== 1'b1 || err0 !== 8'd0) begin bad++; $display("FAIL tx_busy_err got busy=%b err=%0d want 1,0", busy0, err0); end
   endtask

   task automatic test_timeout();
      do_reset();
      skip = 1'b0;
      for (int i = 0; i < 5; i++) begin
         slot();
         total++; if (ins0 !== 12'o6041) begin bad++; $display("FAIL to_ins[%0d] got %o want 6041", i, ins0); end
         total++; if (to0 !== (i == 4)) begin bad++; $display("FAIL to_flag[%0d] got %b want %b", i, to0, i == 4); end
      end
      total++; if (err0 !== 8'd1) begin bad++; $display("FAIL to_err got %0d want 1", err0); end
      skip = 1'b1;
      slot();
      total++; if (ins0 !== 12'o6041) begin bad++; $display("FAIL to_retry_ins got %o want 6041", ins0); end
      slot();
      total++; if (ins0 !== 12'o6046 || ac0 !== 12'o0102) begin bad++;
         $display("FAIL to_next_char got ins=%o ac=%o want 6046/0102", ins0, ac0); end
      total++; if (to0 !== 1'b1 || pass0 !== 8'd0) begin bad++; $display("FAIL to_sticky got to=%b pass=%0d want 1,0", to0, pass0); end
   endtask

   // inject_bad: when set, rx_data returns 8'h00 for the second character of the first message.
   task automatic test_loopback(input bit inject_bad);
      logic [7:0]  chars [5] = '{8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
      logic [11:0] ops [5]   = '{12'o6041, 12'o6046, 12'o6031, 12'o6036, 12'o7000};
      do_reset();
      skip = 1'b1;
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 5; c++) begin
            rx_data = (inject_bad && m == 0 && c == 1) ? 8'h00 : chars[c];
            for (int k = 0; k < 5; k++) begin
               slot();
               total++; if (ins2 !== ops[k]) begin bad++;
                  $display("FAIL loop_ins m%0d c%0d k%0d got %o want %o", m, c, k, ins2, ops[k]); end
               if (k == 1) begin
                  total++; if (ac2 !== {4'b0, chars[c]}) begin bad++;
                     $display("FAIL loop_ac m%0d c%0d got %o want %o", m, c, ac2, {4'b0, chars[c]}); end
               end
            end
         end
         total++; if (pass2 !== ((inject_bad ? 8'd0 : 8'd1) + 8'(m))) begin bad++;
            $display("FAIL loop_pass m%0d got %0d want %0d", m, pass2, (inject_bad ? 0 : 1) + m); end
         total++; if (err2 !== (inject_bad ? 8'd1 : 8'd0)) begin bad++;
            $display("FAIL loop_err m%0d got %0d want %0d", m, err2, inject_bad ? 1 : 0); end
      end
   endtask

   task automatic test_echo();
      logic [11:0] ops [4] = '{12'o6031, 12'o6036, 12'o6041, 12'o6046};
      do_reset();
      skip = 1'b1;
      rx_data = 8'h5A;
      for (int e = 0; e < 2; e++) begin
         for (int k = 0; k < 4; k++) begin
            slot();
            total++; if (ins1 !== ops[k]) begin bad++; $display("FAIL echo_ins e%0d k%0d got %o want %o", e, k, ins1, ops[k]); end
         end
         total++; if (ac1 !== 12'o0132) begin bad++; $display("FAIL echo_ac e%0d got %o want 0132", e, ac1); end
         total++; if (pass1 !== 8'(e)) begin bad++; $display("FAIL echo_pass e%0d got %0d want %0d", e, pass1, e); end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      skip = 1'b1;
      for (int i = 0; i < 11; i++) slot();
      total++; if (pass0 !== 8'd1) begin bad++; $display("FAIL mid_pre_pass got %0d want 1", pass0); end
      state = ST_F0; @(posedge clock); #1;
      total++; if (ins0 !== 12'o6046 || ac0 !== 12'o0101) begin bad++;
         $display("FAIL mid_tls got ins=%o ac=%o want 6046/0101", ins0, ac0); end
      reset = 1'b1; state = ST_F1;
      @(posedge clock); #1;
      reset = 1'b0;
      total++; if (ins0 !== 12'o7000 || ac0 !== 12'o0) begin bad++;
         $display("FAIL mid_reset_io got ins=%o ac=%o want 7000/0", ins0, ac0); end
      total++; if (pass0 !== 8'd0 || err0 !== 8'd0 || busy0 !== 1'b0) begin bad++;
         $display("FAIL mid_reset_stats got pass=%0d err=%0d busy=%b want 0,0,0", pass0, err0, busy0); end
      slot();
      total++; if (ins0 !== 12'o6041) begin bad++; $display("FAIL mid_restart_ins got %o want 6041", ins0); end
      slot();
      total++; if (ins0 !== 12'o6046 || ac0 !== 12'o0101) begin bad++;
         $display("FAIL mid_restart_char got ins=%o ac=%o want 6046/0101", ins0, ac0); end
   endtask

   initial begin
      test_reset();
      test_transmit();
      test_timeout();
      test_loopback(1'b0);
      test_loopback(1'b1);
      test_echo();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
